coin_detect: RTL



---
 rtl/coin_pkg.sv | 34 +++
 rtl/coin_debounce.sv | 56 +++++
 rtl/coin_detect.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/coin_pkg.sv
// Shared types and coin values for the coin-detect front end.
// Optional build macro MULTI_COIN_REJECT_EN is consumed by coin_detect, not here.
package coin_pkg;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_N,
        COIN_D,
        COIN_Q
    } coin_t;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } arb_state_t;

    localparam int CENTS_W = 6;

    localparam logic [CENTS_W-1:0] CENTS_N = 6'd5;
    localparam logic [CENTS_W-1:0] CENTS_D = 6'd10;
    localparam logic [CENTS_W-1:0] CENTS_Q = 6'd25;

    function automatic logic [CENTS_W-1:0] coin_cents_f(input coin_t coin);
        logic [CENTS_W-1:0] cents;
        case (coin)
            COIN_N:  cents = CENTS_N;
            COIN_D:  cents = CENTS_D;
            COIN_Q:  cents = CENTS_Q;
            default: cents = '0;
        endcase
        return cents;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin channel: 2-flop synchroniser, consecutive-sample debounce filter,
// and rising-edge strobe of the filtered level.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_dly_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= raw_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
        end
    end

    // Any sample that agrees with the filtered level restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~level_dly_q;

endmodule

// File: rtl/coin_detect.sv
// Coin front end: three debounced channels feeding a one-event-per-insertion arbiter.
// Build macro MULTI_COIN_REJECT_EN: simultaneous insertions raise coin_reject instead of Q>D>N priority.
module coin_detect
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               N_raw,
    input  logic               D_raw,
    input  logic               Q_raw,
    output logic               coin_N,
    output logic               coin_D,
    output logic               coin_Q,
    output logic               coin_valid,
    output logic [CENTS_W-1:0] coin_cents,
    output logic               coin_reject
);

    // Channel index: 0 = nickel, 1 = dime, 2 = quarter.
    logic [2:0] raw_vec;
    logic [2:0] level_vec;
    logic [2:0] rise_vec;

    assign raw_vec = {Q_raw, D_raw, N_raw};

    for (genvar g = 0; g < 3; g++) begin : g_chan
        coin_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i  (CLK),
            .rst_i  (RST),
            .raw_i  (raw_vec[g]),
            .level_o(level_vec[g]),
            .rise_o (rise_vec[g])
        );
    end

    arb_state_t         state_q;
    arb_state_t         state_d;
    coin_t              sel;
    logic               coin_n_q, coin_n_d;
    logic               coin_d_q, coin_d_d;
    logic               coin_q_q, coin_q_d;
    logic               valid_q, valid_d;
    logic [CENTS_W-1:0] cents_q, cents_d;

    always_comb begin
        sel = COIN_NONE;
        if (rise_vec[2]) begin
            sel = COIN_Q;
        end else if (rise_vec[1]) begin
            sel = COIN_D;
        end else if (rise_vec[0]) begin
            sel = COIN_N;
        end
    end

`ifdef MULTI_COIN_REJECT_EN
    logic multi;
    logic reject_q, reject_d;

    assign multi = (rise_vec[0] & rise_vec[1]) |
                   (rise_vec[0] & rise_vec[2]) |
                   (rise_vec[1] & rise_vec[2]);
`endif

    always_comb begin
        state_d  = state_q;
        coin_n_d = 1'b0;
        coin_d_d = 1'b0;
        coin_q_d = 1'b0;
        valid_d  = 1'b0;
        cents_d  = '0;
`ifdef MULTI_COIN_REJECT_EN
        reject_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (sel != COIN_NONE) begin
                    state_d = S_HOLD;
`ifdef MULTI_COIN_REJECT_EN
                    if (multi) begin
                        reject_d = 1'b1;
                    end else begin
                        coin_n_d = (sel == COIN_N);
                        coin_d_d = (sel == COIN_D);
                        coin_q_d = (sel == COIN_Q);
                        valid_d  = 1'b1;
                        cents_d  = coin_cents_f(sel);
                    end
`else
                    coin_n_d = (sel == COIN_N);
                    coin_d_d = (sel == COIN_D);
                    coin_q_d = (sel == COIN_Q);
                    valid_d  = 1'b1;
                    cents_d  = coin_cents_f(sel);
`endif
                end
            end
            // Stay blind until every switch is back out, so one insertion is one event.
            S_HOLD: begin
                if (level_vec == 3'b000) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            coin_n_q <= 1'b0;
            coin_d_q <= 1'b0;
            coin_q_q <= 1'b0;
            valid_q  <= 1'b0;
            cents_q  <= '0;
`ifdef MULTI_COIN_REJECT_EN
            reject_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            coin_n_q <= coin_n_d;
            coin_d_q <= coin_d_d;
            coin_q_q <= coin_q_d;
            valid_q  <= valid_d;
            cents_q  <= cents_d;
`ifdef MULTI_COIN_REJECT_EN
            reject_q <= reject_d;
`endif
        end
    end

    assign coin_N     = coin_n_q;
    assign coin_D     = coin_d_q;
    assign coin_Q     = coin_q_q;
    assign coin_valid = valid_q;
    assign coin_cents = cents_q;
`ifdef MULTI_COIN_REJECT_EN
    assign coin_reject = reject_q;
`else
    assign coin_reject = 1'b0;
`endif

endmodule
